// File: rtl/gpio_int_v2_pkg.sv
// Shared constants for the parametrised GPIO/interrupt block.
// Register map addresses and edge-mode bit encodings.
package gpio_int_v2_pkg;

  localparam logic [3:0] ADDR_DATA     = 4'd0;
  localparam logic [3:0] ADDR_DIR      = 4'd1;
  localparam logic [3:0] ADDR_EDGE_POS = 4'd2;
  localparam logic [3:0] ADDR_EDGE_NEG = 4'd3;
  localparam logic [3:0] ADDR_INT_EN   = 4'd4;
  localparam logic [3:0] ADDR_STATUS   = 4'd5;
  localparam logic [3:0] ADDR_OUT_SET  = 4'd6;
  localparam logic [3:0] ADDR_OUT_CLR  = 4'd7;
  localparam logic [3:0] ADDR_DEBOUNCE = 4'd8;
  localparam logic [3:0] ADDR_RAW      = 4'd9;

  localparam int EDGE_BIT_POS = 0;
  localparam int EDGE_BIT_NEG = 1;

  localparam logic [1:0] EDGE_NONE = 2'b00;
  localparam logic [1:0] EDGE_RISE = 2'b01;
  localparam logic [1:0] EDGE_FALL = 2'b10;
  localparam logic [1:0] EDGE_ANY  = 2'b11;

  // A transition to `level` hits if the matching edge bit is enabled.
  function automatic logic edgeHit(
    input logic [1:0] mode,
    input logic       level
  );
    return level ? mode[EDGE_BIT_POS] : mode[EDGE_BIT_NEG];
  endfunction

endpackage

// File: rtl/gpio_debounce.sv
// One pin: input synchroniser, debounce counter and filtered level.
// `transition` is high in the cycle filt is about to take sync.
module gpio_debounce #(
  parameter int DEB_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             pin,
  input  logic [DEB_W-1:0] debThr,
  output logic             sync,
  output logic             filt,
  output logic             transition
);

  logic [SYNC_STAGES-1:0] syncQ;
  logic [DEB_W-1:0]       cnt;

  assign sync       = syncQ[SYNC_STAGES-1];
  assign transition = (sync != filt) && (cnt == debThr);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      syncQ <= '0;
    end else begin
      syncQ <= {syncQ[SYNC_STAGES-2:0], pin};
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt  <= '0;
      filt <= 1'b0;
    end else if (sync == filt) begin
      cnt <= '0;
    end else if (cnt == debThr) begin
      filt <= sync;
      cnt  <= '0;
    end else begin
      cnt <= cnt + DEB_W'(1);
    end
  end

endmodule

// File: rtl/gpio_int_v2.sv
// Parametrised GPIO port with debounced per-pin edge interrupts,
// W1C status, atomic output set/clear and one aggregated Irq.
module gpio_int_v2
  import gpio_int_v2_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int DEB_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [3:0]       Addr,
  output logic [WIDTH-1:0] DataRd,
  input  logic [WIDTH-1:0] DataWr,
  input  logic             En,
  input  logic             Rd,
  input  logic             Wr,
  inout  wire  [WIDTH-1:0] Port,
  output logic [WIDTH-1:0] IntStatus,
  input  logic [WIDTH-1:0] IntReset,
  output logic             Irq
);

  logic [WIDTH-1:0] dataOut;
  logic [WIDTH-1:0] dir;
  logic [WIDTH-1:0] edgePos;
  logic [WIDTH-1:0] edgeNeg;
  logic [WIDTH-1:0] intEn;
  logic [DEB_W-1:0] debThr;

  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] filt;
  logic [WIDTH-1:0] transition;
  logic [WIDTH-1:0] evt;
  logic [WIDTH-1:0] clr;
  logic             wrEn;

  assign wrEn = En & Wr;

  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    assign Port[i] = dir[i] ? dataOut[i] : 1'bz;

    gpio_debounce #(
      .DEB_W       (DEB_W),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_deb (
      .Clk        (Clk),
      .Reset      (Reset),
      .pin        (Port[i]),
      .debThr     (debThr),
      .sync       (sync[i]),
      .filt       (filt[i]),
      .transition (transition[i])
    );

    assign evt[i] = transition[i] &
                    edgeHit({edgeNeg[i], edgePos[i]}, sync[i]);
  end

  assign clr = IntReset |
               ((wrEn && Addr == ADDR_STATUS) ? DataWr : '0);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      dataOut <= '0;
      dir     <= '0;
      edgePos <= '0;
      edgeNeg <= '0;
      intEn   <= '0;
      debThr  <= '0;
    end else if (wrEn) begin
      case (Addr)
        ADDR_DATA:     dataOut <= DataWr;
        ADDR_DIR:      dir     <= DataWr;
        ADDR_EDGE_POS: edgePos <= DataWr;
        ADDR_EDGE_NEG: edgeNeg <= DataWr;
        ADDR_INT_EN:   intEn   <= DataWr;
        ADDR_OUT_SET:  dataOut <= dataOut | DataWr;
        ADDR_OUT_CLR:  dataOut <= dataOut & ~DataWr;
        ADDR_DEBOUNCE: debThr  <= DEB_W'(DataWr);
        default: ;
      endcase
    end
  end

  // Set wins: a same-cycle event is ORed in after the clear.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      IntStatus <= '0;
    end else begin
      IntStatus <= (IntStatus & ~clr) | evt;
    end
  end

  assign Irq = |(IntStatus & intEn);

  always_comb begin
    DataRd = '0;
    if (En && Rd) begin
      case (Addr)
        ADDR_DATA:     DataRd = filt;
        ADDR_DIR:      DataRd = dir;
        ADDR_EDGE_POS: DataRd = edgePos;
        ADDR_EDGE_NEG: DataRd = edgeNeg;
        ADDR_INT_EN:   DataRd = intEn;
        ADDR_STATUS:   DataRd = IntStatus;
        ADDR_OUT_SET:  DataRd = dataOut;
        ADDR_OUT_CLR:  DataRd = dataOut;
        ADDR_DEBOUNCE: DataRd = WIDTH'(debThr);
        ADDR_RAW:      DataRd = sync;
        default:       DataRd = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_int_v2.sv
// Directed self-checking bench for gpio_int_v2 (WIDTH=16).
// Pins are driven by a per-bit tri-state driver alongside the DUT.
module tb_gpio_int_v2;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [3:0]  Addr = '0;
  logic [15:0] DataRd;
  logic [15:0] DataWr = '0;
  logic        En = 1'b0;
  logic        Rd = 1'b0;
  logic        Wr = 1'b0;
  wire  [15:0] Port;
  logic [15:0] IntStatus;
  logic [15:0] IntReset = '0;
  logic        Irq;

  logic [15:0] tbOe = '0;
  logic [15:0] tbVal = '0;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  for (genvar g = 0; g < 16; g++) begin : g_drv
    assign Port[g] = tbOe[g] ? tbVal[g] : 1'bz;
  end

  gpio_int_v2 #(
    .WIDTH       (16),
    .DEB_W       (8),
    .SYNC_STAGES (2)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Addr      (Addr),
    .DataRd    (DataRd),
    .DataWr    (DataWr),
    .En        (En),
    .Rd        (Rd),
    .Wr        (Wr),
    .Port      (Port),
    .IntStatus (IntStatus),
    .IntReset  (IntReset),
    .Irq       (Irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    Addr = a; DataWr = d; En = 1'b1; Wr = 1'b1;
    tick(1);
    En = 1'b0; Wr = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [15:0] d);
    Addr = a; En = 1'b1; Rd = 1'b1;
    #1;
    d = DataRd;
    En = 1'b0; Rd = 1'b0;
    #1;
  endtask

  logic [15:0] r;

  initial begin
    // Reset with random bus traffic; pins driven by the bench only
    tbOe = 16'hFFFF; tbVal = 16'hA5C3;
    for (int i = 0; i < 8; i++) begin
      @(posedge Clk); #1;
      Addr = 4'($urandom); DataWr = 16'($urandom);
      En = 1'($urandom); Rd = 1'($urandom); Wr = 1'($urandom);
      #1;
      if (i == 3 || i == 7) chk("rst_rd_rand", DataRd, 16'h0);
    end
    Wr = 1'b0;
    Addr = 4'd5; En = 1'b1; Rd = 1'b1; #1;
    chk("rst_rd_status", DataRd, 16'h0);
    chk("rst_irq", Irq, 1'b0);
    chk("rst_status", IntStatus, 16'h0);
    chk("rst_port_undriven", Port, 16'hA5C3);
    tbVal = 16'h5A3C; #1;
    chk("rst_port_undriven2", Port, 16'h5A3C);
    En = 1'b0; Rd = 1'b0;
    tick(1);
    Reset = 1'b0;
    tick(1);
    rd(4'd1, r); chk("dir_after_rst", r, 16'h0000);
    tick(6);
    chk("post_rst_no_status", IntStatus, 16'h0);

    // Output path with atomic set/clear
    tbOe = 16'h0000;
    wr(4'd1, 16'hFFFF);
    wr(4'd0, 16'h00F0);
    wr(4'd6, 16'h0003);
    wr(4'd7, 16'h0010);
    #1;
    chk("port_out", Port, 16'h00E3);
    rd(4'd6, r); chk("out_set_rd", r, 16'h00E3);
    rd(4'd7, r); chk("out_clr_rd", r, 16'h00E3);

    // Switch to inputs, bench drives everything low
    wr(4'd1, 16'h0000);
    tbVal = 16'h0000; tbOe = 16'hFFFF;
    wr(4'd8, 16'hFF03);
    rd(4'd8, r); chk("deb_rd", r, 16'h0003);
    wr(4'd2, 16'h0004);
    wr(4'd4, 16'h0004);
    tick(12);
    chk("deb_pre_status", IntStatus, 16'h0);

    // 3-clock glitch is filtered out
    tbVal[2] = 1'b1;
    tick(3);
    tbVal[2] = 1'b0;
    tick(10);
    chk("glitch_status", IntStatus, 16'h0);
    rd(4'd0, r); chk("glitch_filt", r, 16'h0000);

    // 6-clock pulse: status exactly 6 clocks after the edge
    tbVal[2] = 1'b1;
    tick(5);
    chk("pulse_early", IntStatus, 16'h0);
    chk("pulse_early_irq", Irq, 1'b0);
    tick(1);
    chk("pulse_status", IntStatus, 16'h0004);
    chk("pulse_irq", Irq, 1'b1);
    rd(4'd0, r); chk("pulse_filt", r, 16'h0004);
    tbVal[2] = 1'b0;
    tick(12);
    chk("pulse_fall_no_evt", IntStatus, 16'h0004);

    // Edge modes with no filtering
    wr(4'd5, 16'hFFFF);
    wr(4'd8, 16'h0000);
    wr(4'd2, 16'h0002);
    wr(4'd3, 16'h0003);
    chk("edge_clr", IntStatus, 16'h0);
    tbVal[1:0] = 2'b11;
    tick(1);
    rd(4'd9, r); chk("raw_read", r, 16'h0000);
    tick(1);
    rd(4'd9, r); chk("raw_read2", r, 16'h0003);
    tick(4);
    chk("edge_rise", IntStatus, 16'h0002);
    tbVal[1:0] = 2'b00;
    tick(6);
    chk("edge_fall", IntStatus, 16'h0003);

    // Mask and W1C
    wr(4'd5, 16'hFFFF);
    wr(4'd4, 16'h0000);
    wr(4'd2, 16'h0020);
    wr(4'd3, 16'h0000);
    tbVal[5] = 1'b1;
    tick(6);
    chk("mask_status", IntStatus, 16'h0020);
    chk("mask_irq", Irq, 1'b0);
    wr(4'd4, 16'h0020);
    chk("unmask_irq", Irq, 1'b1);
    wr(4'd5, 16'h0020);
    chk("w1c_status", IntStatus, 16'h0000);
    chk("w1c_irq", Irq, 1'b0);
    rd(4'd12, r); chk("unmapped_rd", r, 16'h0000);

    // Collision: event and IntReset on the same bit, same cycle
    wr(4'd2, 16'h0080);
    tbVal[7] = 1'b1;
    tick(2);
    chk("coll_pre", IntStatus, 16'h0000);
    IntReset = 16'h0080;
    tick(1);
    IntReset = 16'h0000;
    chk("coll_set_wins", IntStatus, 16'h0080);
    IntReset = 16'h0080;
    tick(1);
    IntReset = 16'h0000;
    chk("coll_clear", IntStatus, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
